// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  localparam logic [3:0] STRB_FULL = 4'b1111;
  localparam logic [3:0] STRB_NONE = 4'b0000;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and RAM pins of the data-RAM arbiter; slave = arbiter side, master = requesters + RAM.
interface dmem_arbiter_if #(parameter int ADDR_W = 32);
  logic              req0_i, req1_i;
  logic              we0_i, we1_i;
  logic [ADDR_W-1:0] addr0_i, addr1_i;
  logic [31:0]       wdata0_i, wdata1_i;
  logic [3:0]        wstrb0_i, wstrb1_i;
  logic              ack0_o, ack1_o;
  logic [31:0]       rdata_o;
  logic              busy_o;
  logic              ram_we_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [31:0]       ram_din_o;
  logic [31:0]       ram_dout_i;

  modport slave (
    input  req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
           wdata0_i, wdata1_i, wstrb0_i, wstrb1_i, ram_dout_i,
    output ack0_o, ack1_o, rdata_o, busy_o, ram_we_o, ram_addr_o, ram_din_o
  );

  modport master (
    output req0_i, req1_i, we0_i, we1_i, addr0_i, addr1_i,
           wdata0_i, wdata1_i, wstrb0_i, wstrb1_i, ram_dout_i,
    input  ack0_o, ack1_o, rdata_o, busy_o, ram_we_o, ram_addr_o, ram_din_o
  );
endinterface

// File: rtl/dmem_byte_merge.sv
// Byte-lane merge: strobed lanes from the new word, the rest from the old word.
module dmem_byte_merge
  import dmem_arb_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = wstrb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter in front of the word-wide data RAM.
// DMEM_ARB_RMW_EN enables byte-lane stores via a read-modify-write pass.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);
  state_t            state_q, state_d;
  logic              last_grant_q, port_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q;
  logic              any_req, grant, latch;
  logic              wr_full, wr_part;
  logic              ram_we, ack0, ack1;

  assign any_req = bus.req0_i | bus.req1_i;
  // On a tie the port not served last wins; a lone requester always wins.
  assign grant   = (bus.req0_i & bus.req1_i) ? ~last_grant_q : bus.req1_i;
  assign latch   = (state_q == IDLE) & any_req;

`ifdef DMEM_ARB_RMW_EN
  logic [3:0]  wstrb_q;
  logic [31:0] merge_q, merged;

  dmem_byte_merge u_merge (
    .old_word (bus.ram_dout_i),
    .new_word (wdata_q),
    .wstrb    (wstrb_q),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstrb_q <= STRB_NONE;
      merge_q <= '0;
    end else begin
      if (latch) wstrb_q <= grant ? bus.wstrb1_i : bus.wstrb0_i;
      if (state_q == ACCESS && wr_part) merge_q <= merged;
    end
  end

  // A null strobe completes without touching the RAM.
  assign wr_full = we_q & (wstrb_q == STRB_FULL);
  assign wr_part = we_q & (wstrb_q != STRB_FULL) & (wstrb_q != STRB_NONE);
  assign bus.ram_din_o = (state_q == WRITE) ? merge_q : wdata_q;
`else
  logic unused_strb;
  assign unused_strb   = ^{bus.wstrb0_i, bus.wstrb1_i};
  assign wr_full       = we_q;
  assign wr_part       = 1'b0;
  assign bus.ram_din_o = wdata_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = wr_part ? WRITE : RESP;
`ifdef DMEM_ARB_RMW_EN
      WRITE:   state_d = RESP;
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_we = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    case (state_q)
      ACCESS:  ram_we = wr_full;
`ifdef DMEM_ARB_RMW_EN
      WRITE:   ram_we = 1'b1;
`endif
      RESP: begin
        ack0 = (port_q == PORT_CPU);
        ack1 = (port_q == PORT_LDR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= PORT_LDR;
      port_q       <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      if (latch) begin
        port_q  <= grant;
        we_q    <= grant ? bus.we1_i    : bus.we0_i;
        addr_q  <= grant ? bus.addr1_i  : bus.addr0_i;
        wdata_q <= grant ? bus.wdata1_i : bus.wdata0_i;
      end
      if (state_q == ACCESS && !we_q) rdata_q <= bus.ram_dout_i;
      if (state_q == RESP) last_grant_q <= port_q;
    end
  end

  // Reset abandons the transaction: no RAM write or ack in the reset cycle.
  assign bus.ram_we_o   = ram_we & rst_n;
  assign bus.ack0_o     = ack0 & rst_n;
  assign bus.ack1_o     = ack1 & rst_n;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.ram_addr_o = addr_q;
  assign bus.rdata_o    = rdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: reference RAM model, expected acks queued at issue.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int NW     = 32;
`ifdef DMEM_ARB_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; } op_t;
  typedef struct { int port; bit rd; logic [31:0] data; int t; } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_chk = 0, n_err = 0;
  int          we_seen = 0, we_exp = 0;
  int          ref_last = 1;
  logic [31:0] ram     [256];
  logic [31:0] ref_mem [256];
  exp_t        exp_q[$];
  exp_t        mon_e;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.ram_dout_i = ram[bus.ram_addr_o[9:2]];
  always @(posedge clk) if (bus.ram_we_o) ram[bus.ram_addr_o[9:2]] <= bus.ram_din_o;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Spec-level cost of an operation in cycles from the sampling IDLE cycle to ack.
  function automatic int lat(op_t o);
    if (RMW && o.we && o.strb != STRB_FULL && o.strb != STRB_NONE) return 3;
    return 2;
  endfunction

  // Apply one operation to the reference memory; returns the word it reads.
  function automatic logic [31:0] model(op_t o);
    int          i;
    logic [31:0] m;
    i = int'(o.addr[9:2]);
    m = '0;
    for (int b = 0; b < 4; b++) if (o.strb[b] || !RMW) m[8*b +: 8] = 8'hFF;
    if (o.we) begin
      ref_mem[i] = (ref_mem[i] & ~m) | (o.wdata & m);
      if (m != 0) we_exp++;
    end
    return ref_mem[i];
  endfunction

  function automatic op_t mk(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    op_t o;
    o.we = we; o.addr = a; o.wdata = d; o.strb = s;
    return o;
  endfunction

  function automatic op_t rnd_op();
    int s;
    s = $urandom_range(0, 3);
    return mk(1'($urandom_range(0, 1)), 32'($urandom_range(0, NW*4-1)), $urandom,
              s == 0 ? STRB_FULL : s == 1 ? STRB_NONE : 4'($urandom));
  endfunction

  task automatic push(int p, op_t o, int t);
    exp_t e;
    e.port = p; e.rd = !o.we; e.data = model(o); e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic set_port(int p, bit req, op_t o);
    if (p == 0) begin
      bus.req0_i = req; bus.we0_i = o.we; bus.addr0_i = o.addr;
      bus.wdata0_i = o.wdata; bus.wstrb0_i = o.strb;
    end else begin
      bus.req1_i = req; bus.we1_i = o.we; bus.addr1_i = o.addr;
      bus.wdata1_i = o.wdata; bus.wstrb1_i = o.strb;
    end
  endtask

  task automatic wait_ack_drop(int p);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      got = (p == 0) ? bus.ack0_o : bus.ack1_o;
    end
    if (!got) begin
      n_chk++; n_err++;
      $display("FAIL ack_timeout: port %0d got no ack in 40 cycles, expected one", p);
    end
    @(posedge clk); #1;
    if (p == 0) bus.req0_i = 1'b0; else bus.req1_i = 1'b0;
  endtask

  // Payload scrambled after the latching edge must have no effect.
  task automatic drive_port(int p, op_t o, bit scr);
    set_port(p, 1'b1, o);
    if (scr) begin
      @(posedge clk); #1;
      set_port(p, 1'b1, mk(~o.we, $urandom, $urandom, 4'($urandom)));
    end
    wait_ack_drop(p);
  endtask

  task automatic run(bit en0, op_t o0, bit en1, op_t o1, bit scr);
    int k, w, t;
    @(posedge clk); #1;
    k = cyc;
    if (en0 && en1) begin
      w = (ref_last == 1) ? 0 : 1;
      t = k + lat(w == 1 ? o1 : o0);
      push(w, w == 1 ? o1 : o0, t);
      push(1 - w, w == 1 ? o0 : o1, t + 1 + lat(w == 1 ? o0 : o1));
      ref_last = 1 - w;
    end else if (en0) begin
      push(0, o0, k + lat(o0)); ref_last = 0;
    end else if (en1) begin
      push(1, o1, k + lat(o1)); ref_last = 1;
    end
    fork
      begin if (en0) drive_port(0, o0, scr); end
      begin if (en1) drive_port(1, o1, scr); end
    join
  endtask

  // Reset lands in the last pre-RESP cycle; the held request is then served afresh.
  task automatic run_reset(op_t o);
    int          l, idx;
    logic [31:0] old;
    @(posedge clk); #1;
    l   = lat(o);
    idx = int'(o.addr[9:2]);
    set_port(0, 1'b1, o);
    repeat (l - 1) @(posedge clk);
    #1;
    rst_n = 1'b0;
    old = ram[idx];
    @(negedge clk);
    check("reset_ram_we", 32'(bus.ram_we_o), 0);
    check("reset_no_ack", 32'({bus.ack0_o, bus.ack1_o}), 0);
    @(posedge clk); #1;
    check("reset_no_ram_write", ram[idx], old);
    check("reset_busy", 32'(bus.busy_o), 0);
    rst_n = 1'b1;
    ref_last = 1;
    push(0, o, cyc + l);
    ref_last = 0;
    wait_ack_drop(0);
  endtask

  initial forever begin
    @(negedge clk);
    if (bus.ram_we_o) we_seen++;
    if (rst_n && (bus.ack0_o || bus.ack1_o)) begin
      check("ack_overlap", 32'(bus.ack0_o & bus.ack1_o), 0);
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_ack: got ack0=%b ack1=%b at cycle %0d, expected none",
                 bus.ack0_o, bus.ack1_o, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_port", 32'(bus.ack1_o), mon_e.port);
        check("ack_cycle", cyc, mon_e.t);
        if (mon_e.rd) check("rdata", bus.rdata_o, mon_e.data);
      end
    end
  end

  initial begin
    op_t z;
    int  m;
    z = mk(1'b0, '0, '0, '0);
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[8] = 32'hCAFEBABE;
    ref_mem[8] = 32'hCAFEBABE;
    set_port(0, 1'b0, z);
    set_port(1, 1'b0, z);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack0", 32'(bus.ack0_o), 0);
    check("rst_ack1", 32'(bus.ack1_o), 0);
    check("rst_ram_we", 32'(bus.ram_we_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_rdata", bus.rdata_o, 0);
    check("rst_ram_addr", bus.ram_addr_o, 0);
    check("rst_ram_din", bus.ram_din_o, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(1'b1, mk(1'b0, 32'h20, 0, 0), 1'b0, z, 1'b0);
    run(1'b0, z, 1'b1, mk(1'b1, 32'h40, 32'h12345678, STRB_FULL), 1'b0);
    run(1'b0, z, 1'b1, mk(1'b0, 32'h40, 0, 0), 1'b0);
    run(1'b1, mk(1'b1, 32'h40, 32'h000000AB, 4'b0001), 1'b0, z, 1'b0);
    run(1'b0, z, 1'b1, mk(1'b0, 32'h40, 0, 0), 1'b0);
    run(1'b1, mk(1'b0, 32'h10, 0, 0), 1'b1, mk(1'b1, 32'h14, $urandom, STRB_FULL), 1'b0);
    run(1'b1, mk(1'b1, 32'h18, $urandom, STRB_FULL), 1'b1, mk(1'b0, 32'h18, 0, 0), 1'b0);
    run(1'b1, mk(1'b1, 32'h44, $urandom, STRB_NONE), 1'b0, z, 1'b0);
    run(1'b1, mk(1'b1, 32'h48, 32'hA5A5A5A5, STRB_FULL), 1'b0, z, 1'b1);
    run(1'b0, z, 1'b1, mk(1'b0, 32'h48, 0, 0), 1'b1);
    run_reset(mk(1'b1, 32'h4C, 32'h00550000, 4'b0100));
    run(1'b0, z, 1'b1, mk(1'b0, 32'h4C, 0, 0), 1'b0);

    for (int n = 0; n < 80; n++) begin
      m = $urandom_range(0, 2);
      run(m != 1, rnd_op(), m != 0, rnd_op(), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("ram_we_pulses", we_seen, we_exp);
    for (int i = 0; i < NW; i++) check("ram_word", ram[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
